// File: rtl/data_mem_responder_pkg.sv
// data_mem_pkg: shared types and defaults for the data memory responder.
// Holds the access-size enum, the responder FSM state enum, default
// parameter values and the alignment-mask helper.
package data_mem_pkg;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int DEF_DEPTH       = 32;
    // Low address bits that must be zero for an access of the given size
    function automatic logic [2:0] align_mask(size_e s);
        return 3'((4'd1 << s) - 4'd1);
    endfunction
endpackage

// File: rtl/data_mem_responder_lane_align.sv
// mem_lane_align: byte-lane extraction/extension for loads and byte merge for stores.
// Ports:
//   i_lane       - byte offset within the doubleword (addr[2:0])
//   i_size       - access size
//   i_unsigned   - zero-extend loads when 1, sign-extend when 0
//   i_wdata      - right-aligned store data
//   i_old        - current contents of the addressed doubleword
//   o_rdata      - right-aligned, extended load data
//   o_merged     - doubleword with the addressed bytes replaced by store data
//   o_misaligned - address is not a multiple of the access size
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [2:0]  i_lane,
    input  size_e       i_size,
    input  logic        i_unsigned,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_old,
    output logic [63:0] o_rdata,
    output logic [63:0] o_merged,
    output logic        o_misaligned
);
    logic [5:0]  w_sh;
    logic [63:0] w_raw;
    logic [63:0] w_mask;
    logic        w_sign;

    always_comb begin
        w_sh   = {i_lane, 3'b000};
        w_raw  = i_old >> w_sh;
        w_mask = i_size == SZ_B ? 64'hFF :
                 i_size == SZ_H ? 64'hFFFF :
                 i_size == SZ_W ? 64'hFFFF_FFFF : '1;
        w_sign = i_size == SZ_B ? w_raw[7] :
                 i_size == SZ_H ? w_raw[15] : w_raw[31];
        // Doubles are never extended, so the fill only applies below 64 bits
        o_rdata = (w_raw & w_mask) |
                  ((i_size != SZ_D && !i_unsigned && w_sign) ? ~w_mask : 64'd0);
        o_merged = (i_old & ~(w_mask << w_sh)) | ((i_wdata & w_mask) << w_sh);
        o_misaligned = |(i_lane & align_mask(i_size));
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data memory with valid/ready request and response.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready   - request handshake; ready only while idle
//   req_write, req_addr, req_wdata, req_size, req_unsigned - request fields
//   resp_valid/resp_ready - response handshake; valid only while responding
//   resp_rdata, resp_err  - extended load data and error flag
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int DEPTH       = DEF_DEPTH
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);

    state_e      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_write, r_unsigned;
    logic [63:0] r_addr, r_wdata;
    size_e       r_size;
    logic [63:0] r_rdata;
    logic        r_err;
    logic [63:0] r_mem [DEPTH];

    logic          w_idle, w_accept, w_access, w_err, w_mis;
    logic          w_write, w_unsigned;
    logic [63:0]   w_addr, w_wdata, w_old, w_ld, w_st;
    size_e         w_size;
    logic [AW-1:0] w_idx;

    // With zero wait states the access happens on the acceptance edge, before
    // the captured registers are valid, so the live request fields are used.
    always_comb begin
        w_idle     = r_state == IDLE;
        w_accept   = w_idle && req_valid;
        w_access   = (r_state == WAIT && r_cnt == 4'd1) || (w_accept && WAIT_CYCLES == 0);
        w_write    = w_idle ? req_write : r_write;
        w_addr     = w_idle ? req_addr : r_addr;
        w_wdata    = w_idle ? req_wdata : r_wdata;
        w_size     = w_idle ? size_e'(req_size) : r_size;
        w_unsigned = w_idle ? req_unsigned : r_unsigned;
        w_idx      = w_addr[3 +: AW];
        w_old      = r_mem[w_idx];
        w_err      = w_mis || (w_addr[63:3] >= 61'(DEPTH));
    end

    mem_lane_align u_align (
        .i_lane       (w_addr[2:0]),
        .i_size       (w_size),
        .i_unsigned   (w_unsigned),
        .i_wdata      (w_wdata),
        .i_old        (w_old),
        .o_rdata      (w_ld),
        .o_merged     (w_st),
        .o_misaligned (w_mis)
    );

    always_comb begin
        w_next = r_state == IDLE ? (req_valid ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE) :
                 r_state == WAIT ? (r_cnt == 4'd1 ? RESP : WAIT) :
                 (resp_ready ? IDLE : RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt      <= 4'(WAIT_CYCLES);
                r_write    <= req_write;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_size     <= size_e'(req_size);
                r_unsigned <= req_unsigned;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_rdata <= (w_err || w_write) ? 64'd0 : w_ld;
                r_err   <= w_err;
            end
        end
    end

    // Storage keeps its contents through reset; a held reset blocks the write
    always_ff @(posedge clk) begin
        if (rst && w_access && w_write && !w_err) r_mem[w_idx] <= w_st;
    end

    always_comb begin
        req_ready  = r_state == IDLE;
        resp_valid = r_state == RESP;
        resp_rdata = r_rdata;
        resp_err   = r_err;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized self-checking bench against a byte-array memory model.
module tb_data_mem_responder;
    localparam int WC  = 2;
    localparam int DEP = 32;
    localparam int NB  = DEP * 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [63:0] resp_rdata;

    logic        b_req_valid = 1'b0, b_req_write = 1'b0;
    logic [63:0] b_req_addr = '0, b_req_wdata = '0;
    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic [63:0] b_resp_rdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]  mb [NB];
    logic [63:0] b_model [4];

    always #5 clk = ~clk;

    data_mem_responder #(.WAIT_CYCLES(WC), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.WAIT_CYCLES(0), .DEPTH(DEP)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .req_size(2'b11), .req_unsigned(1'b0), .resp_valid(b_resp_valid),
        .resp_ready(1'b1), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [63:0] a, input logic [1:0] sz);
        return ((a % (64'd1 << sz)) != 0) || (a >= 64'(NB));
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] sz, input logic u);
        int n = 1 << sz;
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v |= 64'(mb[int'(a) + i]) << (8 * i);
        if (!u && n < 8 && v[8 * n - 1]) v |= ~64'd0 << (8 * n);
        return v;
    endfunction

    // One full transaction on the WAIT_CYCLES=2 instance, checked against the model
    task automatic run(input string tag, input logic w, input logic [63:0] a, input logic [63:0] wd,
                       input logic [1:0] sz, input logic u);
        logic        e;
        logic [63:0] exp;
        int          k, lat;
        e   = model_err(a, sz);
        exp = (e || w) ? 64'd0 : model_load(a, sz, u);
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        check({tag, "_rdy"}, req_ready, 1'b1);
        req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = u;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin @(negedge clk); lat++; end
        check({tag, "_lat"}, 64'(lat), 64'(WC + 1));
        check({tag, "_err"}, resp_err, e);
        check({tag, "_rdata"}, resp_rdata, exp);
        if (w && !e)
            for (int i = 0; i < (1 << sz); i++) mb[int'(a) + i] = wd[8 * i +: 8];
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_idle"}, {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        logic [63:0] a, wd, held;
        logic [1:0]  sz;
        int          k;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_valid", resp_valid, 1'b0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_err", resp_err, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Fill storage so every model byte is defined
        for (int i = 0; i < DEP; i++) run("fill", 1'b1, 64'(i * 8), {$urandom, $urandom}, 2'b11, 1'b0);

        run("st_d10", 1'b1, 64'h10, 64'h1122334455667788, 2'b11, 1'b0);
        run("ld_d10", 1'b0, 64'h10, 64'h0, 2'b11, 1'b0);
        check("ld_d10_const", resp_rdata, 64'h1122334455667788);
        run("ld_b17", 1'b0, 64'h17, 64'h0, 2'b00, 1'b0);
        check("ld_b17_const", resp_rdata, 64'h11);
        run("st_b11", 1'b1, 64'h11, 64'hF0, 2'b00, 1'b0);
        run("ld_b11s", 1'b0, 64'h11, 64'h0, 2'b00, 1'b0);
        check("ld_b11s_const", resp_rdata, 64'hFFFFFFFFFFFFFFF0);
        run("ld_b11u", 1'b0, 64'h11, 64'h0, 2'b00, 1'b1);
        check("ld_b11u_const", resp_rdata, 64'hF0);
        run("ld_w12", 1'b0, 64'h12, 64'h0, 2'b10, 1'b0);
        run("st_oor", 1'b1, 64'h100, 64'hDEADBEEFCAFEF00D, 2'b11, 1'b0);
        run("ld_d00", 1'b0, 64'h0, 64'h0, 2'b11, 1'b0);

        // Stall in RESP with a competing request that must be ignored
        req_write = 1'b0; req_addr = 64'h10; req_size = 2'b11; req_unsigned = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 40) begin @(negedge clk); k++; end
        check("stall_valid0", resp_valid, 1'b1);
        held = model_load(64'h10, 2'b11, 1'b0);
        req_write = 1'b1; req_wdata = 64'hDEAD_DEAD_DEAD_DEAD; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", resp_valid, 1'b1);
            check("stall_ready", req_ready, 1'b0);
            check("stall_rdata", resp_rdata, held);
            check("stall_err", resp_err, 1'b0);
        end
        resp_ready = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        check("stall_release", {resp_valid, req_ready}, 2'b01);
        run("stall_noacc", 1'b0, 64'h10, 64'h0, 2'b11, 1'b0);

        // Reset while a store sits in WAIT: it must never land
        run("pre_b08", 1'b1, 64'h08, 64'h55, 2'b00, 1'b0);
        req_write = 1'b1; req_addr = 64'h08; req_wdata = 64'hAA; req_size = 2'b00; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_ready", req_ready, 1'b1);
        check("abort_valid", resp_valid, 1'b0);
        check("abort_rdata", resp_rdata, 64'd0);
        check("abort_err", resp_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run("abort_ld08", 1'b0, 64'h08, 64'h0, 2'b00, 1'b1);
        check("abort_ld08_const", resp_rdata, 64'h55);

        // Randomized mix of loads and stores
        for (int i = 0; i < 80; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 64'($urandom_range(0, NB + 15));
            if ($urandom_range(0, 9) < 7) a = a & ~64'((1 << sz) - 1);
            if ($urandom_range(0, 19) == 0) a = {$urandom, $urandom};
            wd = {$urandom, $urandom};
            run("rnd", 1'($urandom_range(0, 1)), a, wd, sz, 1'($urandom_range(0, 1)));
        end

        // Zero-wait instance, response always accepted, request held high
        b_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("b2b_ready", b_req_ready, 1'b1);
            b_req_write = i < 4;
            b_req_addr  = 64'((i % 4) * 8);
            b_req_wdata = {$urandom, $urandom};
            @(posedge clk);
            if (i < 4) b_model[i] = b_req_wdata;
            @(negedge clk);
            check("b2b_valid", b_resp_valid, 1'b1);
            check("b2b_busy", b_req_ready, 1'b0);
            check("b2b_err", b_resp_err, 1'b0);
            check("b2b_rdata", b_resp_rdata, i < 4 ? 64'd0 : b_model[i % 4]);
            @(negedge clk);
        end
        b_req_valid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
